ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED "set LEDs" followed by its argument byte, over the same open-drain ps2_clk/ps2_data lines that the keyboard receiver (ps2_keyboard) listens on. The block performs the clock-inhibit/request-to-send sequence, shifts the 11-bit frame on device-generated clock edges, checks the device ACK, and enforces a timeout. It sits beside ps2_keyboard in the keyboard subsystem, and the pad logic ties its open-drain enables to the bidirectional pins.

---
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device-clocked
// 11-bit frame shift, ACK check and transfer timeout over open-drain lines.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned MAX_AB     = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned MAX_CYC    = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYC) + 1;
  localparam int unsigned FW         = 10;
  localparam int unsigned BW         = 4;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t          state, next_state;
  logic [FW-1:0]   frame;
  logic [BW-1:0]   bitcnt;
  logic [CW-1:0]   cyc;
  logic            err, err_d;
  logic            clk_s1, clk_s2, clk_s3;
  logic            data_s1, data_s2;
  logic            tx_ready_d, busy_d, done_d, error_d, clk_oe_d, data_oe_d;

  logic clk_fall, lines_idle, accept, timeout, inh_end, req_end, last_fall;

  assign clk_fall   = clk_s3 & ~clk_s2;
  assign lines_idle = clk_s2 & data_s2;
  assign accept     = tx_valid && (state == S_IDLE);
  assign timeout    = ((state == S_SHIFT) || (state == S_WAIT_IDLE)) &&
                      (cyc == CW'(TIMEOUT_CYCLES - 1));
  assign inh_end    = (cyc == CW'(INHIBIT_CYCLES - 1));
  assign req_end    = (cyc == CW'(REQ_CYCLES - 1));
  assign last_fall  = clk_fall && (bitcnt == BW'(FRAME_BITS));

  // Pin synchronisers; the third clock flop provides the previous level for edge detect.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; timeout takes priority over the ACK fall.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (accept) next_state = S_INHIBIT;
      S_INHIBIT:   if (inh_end) next_state = S_REQ;
      S_REQ:       if (req_end) next_state = S_SHIFT;
      S_SHIFT: begin
        if (timeout)        next_state = S_DONE;
        else if (last_fall) next_state = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (timeout || lines_idle) next_state = S_DONE;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Output logic, decoded from the next state so the registered outputs track the state.
  always_comb begin
    err_d      = err;
    tx_ready_d = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    clk_oe_d   = 1'b0;
    data_oe_d  = 1'b0;
    if (accept)                             err_d = 1'b0;
    else if (timeout)                       err_d = 1'b1;
    else if ((state == S_SHIFT) && last_fall) err_d = data_s2;
    case (next_state)
      S_IDLE: begin
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      S_INHIBIT: clk_oe_d = 1'b1;
      S_REQ: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
      end
      S_SHIFT: begin
        // Start bit stays on the line until the first device fall.
        if ((state == S_SHIFT) && clk_fall && (bitcnt < BW'(FRAME_BITS)))
          data_oe_d = ~frame[bitcnt];
        else
          data_oe_d = ps2_data_oe;
      end
      S_DONE: begin
        done_d  = 1'b1;
        error_d = err_d;
      end
      default: ;
    endcase
  end

  // Frame, bit counter, cycle counter and error flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame  <= '0;
      bitcnt <= '0;
      cyc    <= '0;
      err    <= 1'b0;
    end else begin
      err <= err_d;
      case (state)
        S_IDLE: begin
          if (accept) begin
            frame  <= {1'b1, ~^tx_data, tx_data};
            bitcnt <= '0;
            cyc    <= '0;
          end
        end
        S_INHIBIT: cyc <= inh_end ? '0 : cyc + CW'(1);
        S_REQ:     cyc <= req_end ? '0 : cyc + CW'(1);
        S_SHIFT: begin
          cyc <= cyc + CW'(1);
          if (clk_fall && (bitcnt < BW'(FRAME_BITS))) bitcnt <= bitcnt + BW'(1);
        end
        S_WAIT_IDLE: cyc <= cyc + CW'(1);
        S_DONE:      cyc <= '0;
        default:     cyc <= '0;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_ready    <= tx_ready_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 500;
  localparam int unsigned REQC = 16;
  localparam int unsigned TO   = 3000;
  localparam int          H    = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic last_err, last_cloe, last_doe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Open-drain wired lines with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  // Record every done pulse and the line state alongside it.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      last_err  <= error;
      last_cloe <= ps2_clk_oe;
      last_doe  <= ps2_data_oe;
    end
  end

  // Device side: measures inhibit/request, clocks 10 bits in, then ACK clock.
  task automatic dev_frame(input bit ack, output int inh, output int req,
                           output logic [10:0] bits, output bit ok);
    int n;
    ok = 1'b1; inh = 0; req = 0; bits = '0; n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (ps2_clk_oe !== 1'b1) ok = 1'b0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe !== 1'b1 && inh < int'(INH) + 50) begin
      inh++; @(negedge clk);
    end
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && req < int'(REQC) + 50) begin
      req++; @(negedge clk);
    end
    if (ps2_clk_oe !== 1'b0) ok = 1'b0;
    repeat (10) @(negedge clk);
    bits[0] = ps2_data_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      bits[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    if (ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  // Issue one request, run the device, wait for completion.
  task automatic run_send(input logic [7:0] d, input bit ack, output logic cloe_next,
                          output int inh, output int req, output logic [10:0] bits,
                          output int ndone, output bit ok);
    int start, n;
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1; start = done_cnt;
    @(negedge clk);
    tx_valid = 1'b0;
    cloe_next = ps2_clk_oe;
    dev_frame(ack, inh, req, bits, ok);
    n = 0;
    while (done_cnt == start && n < 200) begin @(negedge clk); n++; end
    if (done_cnt == start) ok = 1'b0;
    repeat (5) @(negedge clk);
    ndone = done_cnt - start;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL rst_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({tx_ready, busy, done_cnt == 0} !== 3'b101) begin errors++; $display("FAIL rst_release: got %b want 101", {tx_ready, busy, done_cnt == 0}); end
  endtask

  task automatic test_send_ed();
    logic cn; int inh, req, nd; logic [10:0] bits; bit ok;
    run_send(8'hED, 1'b1, cn, inh, req, bits, nd, ok);
    checks++; if (cn !== 1'b1) begin errors++; $display("FAIL ed_accept_latency: clk_oe %b want 1", cn); end
    checks++; if (inh != int'(INH)) begin errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH); end
    checks++; if (req != int'(REQC)) begin errors++; $display("FAIL ed_req_len: got %0d want %0d", req, REQC); end
    checks++; if (bits !== 11'b1_1_11101101_0) begin errors++; $display("FAIL ed_bits: got %b want %b", bits, 11'b1_1_11101101_0); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ed_handshake: got %b want 1", ok); end
    checks++; if (nd != 1 || last_err !== 1'b0) begin errors++; $display("FAIL ed_done: count %0d err %b want 1 0", nd, last_err); end
    checks++; if ({last_cloe, last_doe, tx_ready, busy} !== 4'b0010) begin errors++; $display("FAIL ed_idle: got %b want 0010", {last_cloe, last_doe, tx_ready, busy}); end
  endtask

  task automatic test_parity();
    logic [7:0]  din  [3];
    logic [10:0] want [3];
    logic cn; int inh, req, nd; logic [10:0] bits; bit ok;
    din[0] = 8'hFF; want[0] = 11'b1_1_11111111_0;
    din[1] = 8'h01; want[1] = 11'b1_0_00000001_0;
    din[2] = 8'h00; want[2] = 11'b1_1_00000000_0;
    for (int k = 0; k < 3; k++) begin
      run_send(din[k], 1'b1, cn, inh, req, bits, nd, ok);
      checks++; if (bits !== want[k]) begin errors++; $display("FAIL parity_bits_%h: got %b want %b", din[k], bits, want[k]); end
      checks++; if (ok !== 1'b1 || nd != 1 || last_err !== 1'b0) begin errors++; $display("FAIL parity_done_%h: ok %b count %0d err %b want 1 1 0", din[k], ok, nd, last_err); end
    end
  endtask

  task automatic test_no_ack();
    logic cn; int inh, req, nd; logic [10:0] bits; bit ok;
    run_send(8'h55, 1'b0, cn, inh, req, bits, nd, ok);
    checks++; if (bits !== 11'b1_1_01010101_0) begin errors++; $display("FAIL noack_bits: got %b want %b", bits, 11'b1_1_01010101_0); end
    checks++; if (nd != 1 || last_err !== 1'b1) begin errors++; $display("FAIL noack_done: count %0d err %b want 1 1", nd, last_err); end
    checks++; if ({last_cloe, last_doe} !== 2'b00) begin errors++; $display("FAIL noack_oe: got %b want 00", {last_cloe, last_doe}); end
  endtask

  task automatic test_timeout();
    int n, inh, req, start; logic [10:0] bits; bit ok;
    @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < int'(INH + REQC) + 50) begin @(negedge clk); n++; end
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL to_release: clk_oe %b want 0", ps2_clk_oe); end
    n = 0;
    while (done !== 1'b1 && n < int'(TO) + 100) begin @(negedge clk); n++; end
    checks++; if (n != int'(TO)) begin errors++; $display("FAIL to_latency: got %0d want %0d", n, TO); end
    checks++; if ({done, error, ps2_clk_oe, ps2_data_oe} !== 4'b1100) begin errors++; $display("FAIL to_done: got %b want 1100", {done, error, ps2_clk_oe, ps2_data_oe}); end
    @(negedge clk);
    checks++; if ({tx_ready, done} !== 2'b10) begin errors++; $display("FAIL to_ready: got %b want 10", {tx_ready, done}); end
    tx_data = 8'h00; tx_valid = 1'b1; start = done_cnt;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL to_next_accept: clk_oe %b want 1", ps2_clk_oe); end
    dev_frame(1'b1, inh, req, bits, ok);
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - start != 1 || last_err !== 1'b0 || bits !== 11'b1_1_00000000_0) begin
      errors++; $display("FAIL to_next_frame: count %0d err %b bits %b want 1 0 %b", done_cnt - start, last_err, bits, 11'b1_1_00000000_0);
    end
  endtask

  task automatic test_reset_mid();
    int n, start, inh, req, nd; logic cn; logic [10:0] bits; bit ok;
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < int'(INH + REQC) + 50) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i < 4) begin dev_clk_low = 1'b0; repeat (H) @(negedge clk); end
    end
    checks++; if ({busy, ps2_data_oe} !== 2'b11) begin errors++; $display("FAIL midrst_before: busy/data_oe %b want 11", {busy, ps2_data_oe}); end
    start = done_cnt;
    #2 clrn = 1'b0;
    #1;
    checks++; if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001) begin errors++; $display("FAIL midrst_async: got %b want 0001", {ps2_clk_oe, ps2_data_oe, busy, tx_ready}); end
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (done_cnt != start || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_done: pulses %0d busy %b want 0 0", done_cnt - start, busy); end
    run_send(8'hF4, 1'b1, cn, inh, req, bits, nd, ok);
    checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL midrst_f4_bits: got %b want %b", bits, 11'b1_0_11110100_0); end
    checks++; if (ok !== 1'b1 || nd != 1 || last_err !== 1'b0) begin errors++; $display("FAIL midrst_f4_done: ok %b count %0d err %b want 1 1 0", ok, nd, last_err); end
  endtask

  task automatic test_back_to_back();
    int inh, req, start, n; logic [10:0] bits; bit ok;
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1; start = done_cnt;
    fork
      dev_frame(1'b1, inh, req, bits, ok);
      begin
        n = 0;
        while (n < 3000) begin
          @(negedge clk);
          if (done === 1'b1) break;
          tx_data = tx_data + 8'h13;
          n++;
        end
        tx_valid = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    checks++; if (bits !== 11'b1_1_10100101_0) begin errors++; $display("FAIL hold_bits: got %b want %b", bits, 11'b1_1_10100101_0); end
    checks++; if (done_cnt - start != 1 || last_err !== 1'b0) begin errors++; $display("FAIL hold_done: count %0d err %b want 1 0", done_cnt - start, last_err); end
    checks++; if ({busy, tx_ready} !== 2'b01) begin errors++; $display("FAIL hold_idle: got %b want 01", {busy, tx_ready}); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_no_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
